// File: rtl/jk_bank_seq.sv
// jk_bank_seq: command sequencer for a bank of WIDTH JK flip-flops.
// Turns CLEAR/SET/LOAD/TOGGLE/COUNT commands into registered per-bit
// J/K excitation, with a settle cycle between drives so q_fb can update.
module jk_bank_seq #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_arg,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             busy,
    output logic             done,
    output logic             wrap
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_SETTLE,
        S_FIN
    } state_t;

    typedef enum logic [2:0] {
        OP_NOP        = 3'd0,
        OP_CLEAR      = 3'd1,
        OP_SET        = 3'd2,
        OP_LOAD       = 3'd3,
        OP_TOGGLE     = 3'd4,
        OP_COUNT_UP   = 3'd5,
        OP_COUNT_DOWN = 3'd6,
        OP_RSVD       = 3'd7
    } op_t;

    state_t           state, state_nxt;
    op_t              op_r, op_nxt, op_in;
    logic [WIDTH-1:0] cnt, cnt_nxt;
    logic             wrap_flag, wrap_nxt;
    logic [WIDTH-1:0] j_nxt, k_nxt;

    // Per-bit JK excitation; count ops toggle bit i when the lower bits carry/borrow.
    function automatic logic [2*WIDTH-1:0] excite(input op_t op,
                                                   input logic [WIDTH-1:0] arg,
                                                   input logic [WIDTH-1:0] q);
        logic [WIDTH-1:0] jx, kx;
        logic             carry;
        jx    = '0;
        kx    = '0;
        carry = 1'b1;
        case (op)
            OP_CLEAR:  kx = '1;
            OP_SET:    jx = '1;
            OP_LOAD: begin
                jx = arg & ~q;
                kx = ~arg & q;
            end
            OP_TOGGLE: begin
                jx = arg;
                kx = arg;
            end
            OP_COUNT_UP, OP_COUNT_DOWN: begin
                for (int unsigned i = 0; i < WIDTH; i++) begin
                    jx[i] = carry;
                    kx[i] = carry;
                    carry = carry & ((op == OP_COUNT_UP) ? q[i] : ~q[i]);
                end
            end
            default: ;
        endcase
        return {jx, kx};
    endfunction

    function automatic logic is_count(input op_t op);
        return (op == OP_COUNT_UP) || (op == OP_COUNT_DOWN);
    endfunction

    function automatic logic wraps_at(input op_t op, input logic [WIDTH-1:0] q);
        return ((op == OP_COUNT_UP) && (&q)) || ((op == OP_COUNT_DOWN) && (q == '0));
    endfunction

    assign op_in = op_t'(cmd_op);

    // Next-state, next J/K drive and handshake/status outputs.
    always_comb begin
        state_nxt = state;
        op_nxt    = op_r;
        cnt_nxt   = cnt;
        wrap_nxt  = wrap_flag;
        j_nxt     = '0;
        k_nxt     = '0;
        cmd_ready = (state == S_IDLE);
        busy      = (state != S_IDLE);
        done      = (state == S_FIN);
        wrap      = (state == S_FIN) && wrap_flag;
        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_nxt   = op_in;
                    wrap_nxt = 1'b0;
                    cnt_nxt  = is_count(op_in) ? cmd_arg : '0;
                    if ((op_in == OP_NOP) || (op_in == OP_RSVD) ||
                        (is_count(op_in) && (cmd_arg == '0))) begin
                        state_nxt = S_FIN;
                    end else begin
                        state_nxt      = S_DRIVE;
                        {j_nxt, k_nxt} = excite(op_in, cmd_arg, q_fb);
                        wrap_nxt       = wraps_at(op_in, q_fb);
                    end
                end
            end
            S_DRIVE: begin
                state_nxt = S_SETTLE;
                if (is_count(op_r)) cnt_nxt = cnt - WIDTH'(1);
            end
            S_SETTLE: begin
                // Next count step uses q_fb already updated by the previous drive.
                if (is_count(op_r) && (cnt != '0)) begin
                    state_nxt      = S_DRIVE;
                    {j_nxt, k_nxt} = excite(op_r, '0, q_fb);
                    if (wraps_at(op_r, q_fb)) wrap_nxt = 1'b1;
                end else begin
                    state_nxt = S_FIN;
                end
            end
            S_FIN:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State, command and registered J/K drive, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            op_r      <= OP_NOP;
            cnt       <= '0;
            wrap_flag <= 1'b0;
            j         <= '0;
            k         <= '0;
        end else begin
            state     <= state_nxt;
            op_r      <= op_nxt;
            cnt       <= cnt_nxt;
            wrap_flag <= wrap_nxt;
            j         <= j_nxt;
            k         <= k_nxt;
        end
    end

endmodule

// File: tb/tb_jk_bank_seq.sv
// Testbench for jk_bank_seq with a behavioural JK bank closing the q_fb loop.
module tb_jk_bank_seq;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [2:0]   cmd_op;
    logic [W-1:0] cmd_arg;
    logic [W-1:0] q_fb;
    logic [W-1:0] j, k;
    logic         busy, done, wrap;
    logic [W-1:0] bank_q;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [W-1:0] q;
        logic         wr;
        int           lat;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] steps[$];
    logic [W-1:0] model_q;

    always #5 clk = ~clk;

    // Behavioural bank of JK flip-flops, no reset.
    always @(posedge clk) bank_q <= (j & ~bank_q) | (~k & bank_q);
    assign q_fb = bank_q;

    jk_bank_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_arg   (cmd_arg),
        .q_fb      (q_fb),
        .j         (j),
        .k         (k),
        .busy      (busy),
        .done      (done),
        .wrap      (wrap)
    );

    // Reference model: expected bank after each step, final bank, wrap and done latency.
    task automatic predict(input logic [2:0] op, input logic [W-1:0] arg);
        exp_t e;
        e.wr  = 1'b0;
        e.lat = 2;
        case (op)
            3'd1: model_q = 4'h0;
            3'd2: model_q = 4'hF;
            3'd3: model_q = arg;
            3'd4: model_q = model_q ^ arg;
            3'd5, 3'd6: begin
                e.lat = 2 * int'(arg);
                for (int s = 0; s < int'(arg); s++) begin
                    if (op == 3'd5) begin
                        if (model_q == 4'hF) e.wr = 1'b1;
                        model_q = model_q + 4'd1;
                    end else begin
                        if (model_q == 4'h0) e.wr = 1'b1;
                        model_q = model_q - 4'd1;
                    end
                    steps.push_back(model_q);
                end
            end
            default: e.lat = 0;
        endcase
        if (op >= 3'd1 && op <= 3'd4) steps.push_back(model_q);
        e.q = model_q;
        sb.push_back(e);
    endtask

    task automatic run_cmd(input logic [2:0] op, input logic [W-1:0] arg,
                           input logic chk_jk, input logic [W-1:0] exp_j,
                           input logic [W-1:0] exp_k, input string name);
        int           idx;
        int           hold_err;
        logic         got;
        exp_t         e;
        logic [W-1:0] sq;
        predict(op, arg);
        @(negedge clk);
        cmd_op    = op;
        cmd_arg   = arg;
        cmd_valid = 1'b1;
        idx = 0;
        while (cmd_ready !== 1'b1 && idx < 50) begin
            @(negedge clk);
            idx++;
        end
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s accept: cmd_ready=%b required=1", name, cmd_ready);
        end
        @(posedge clk);
        #1;
        // Junk on the command inputs while busy must be ignored.
        if (sb[0].lat > 0) begin
            cmd_valid = 1'b1;
            cmd_op    = 3'($urandom_range(7));
            cmd_arg   = 4'($urandom_range(15));
        end else begin
            cmd_valid = 1'b0;
        end
        got      = 1'b0;
        hold_err = 0;
        for (idx = 0; idx <= 40; idx++) begin
            if (idx == 0 && chk_jk) begin
                total++;
                if (j !== exp_j || k !== exp_k) begin
                    bad++;
                    $display("FAIL %s jk: j=%b k=%b required j=%b k=%b", name, j, k, exp_j, exp_k);
                end
            end
            if (idx % 2 == 1 && steps.size() > 0 && done !== 1'b1) begin
                sq = steps.pop_front();
                total++;
                if (q_fb !== sq) begin
                    bad++;
                    $display("FAIL %s step@%0d: q_fb=%b required=%b", name, idx, q_fb, sq);
                end
            end
            if (done === 1'b1) begin
                got = 1'b1;
                break;
            end
            if (busy !== 1'b1 || cmd_ready !== 1'b0) hold_err++;
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        e = sb.pop_front();
        total++;
        if (!got) begin
            bad++;
            $display("FAIL %s done_timeout: done never seen, required after %0d cycles", name, e.lat);
        end else begin
            if (idx !== e.lat) begin
                bad++;
                $display("FAIL %s latency: %0d required=%0d", name, idx, e.lat);
            end
            total++;
            if (q_fb !== e.q) begin
                bad++;
                $display("FAIL %s result: q_fb=%b required=%b", name, q_fb, e.q);
            end
            total++;
            if (wrap !== e.wr) begin
                bad++;
                $display("FAIL %s wrap: wrap=%b required=%b", name, wrap, e.wr);
            end
            if (e.lat > 0) begin
                total++;
                if (hold_err != 0) begin
                    bad++;
                    $display("FAIL %s busy_hold: %0d bad cycles required=0", name, hold_err);
                end
            end
        end
        steps.delete();
        @(posedge clk);
        #1;
        total++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || wrap !== 1'b0) begin
            bad++;
            $display("FAIL %s idle_after: ready=%b busy=%b done=%b wrap=%b required 1000",
                     name, cmd_ready, busy, done, wrap);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_arg   = '0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (j !== 4'h0 || k !== 4'h0 || busy !== 1'b0 || done !== 1'b0 || wrap !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: j=%b k=%b busy=%b done=%b wrap=%b required all 0",
                     j, k, busy, done, wrap);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: cmd_ready=%b busy=%b required 1 0", cmd_ready, busy);
        end
    endtask

    task automatic test_clear_set();
        run_cmd(3'd1, 4'h0, 1'b1, 4'h0, 4'hF, "clear");
        run_cmd(3'd2, 4'h0, 1'b1, 4'hF, 4'h0, "set");
    endtask

    task automatic test_load();
        run_cmd(3'd3, 4'b0101, 1'b0, '0, '0, "load_init");
        run_cmd(3'd3, 4'b1100, 1'b1, 4'b1000, 4'b0001, "load");
    endtask

    task automatic test_count_up();
        run_cmd(3'd3, 4'b1101, 1'b0, '0, '0, "cu_init");
        run_cmd(3'd5, 4'd5, 1'b1, 4'b0011, 4'b0011, "count_up5");
    endtask

    task automatic test_count_down();
        run_cmd(3'd3, 4'b0011, 1'b0, '0, '0, "cd_init");
        run_cmd(3'd6, 4'd3, 1'b1, 4'b0001, 4'b0001, "count_down3");
        run_cmd(3'd6, 4'd1, 1'b1, 4'b1111, 4'b1111, "count_down_wrap");
    endtask

    task automatic test_toggle_nop();
        run_cmd(3'd3, 4'b1010, 1'b0, '0, '0, "tg_init");
        run_cmd(3'd4, 4'b0110, 1'b1, 4'b0110, 4'b0110, "toggle");
        run_cmd(3'd0, 4'b1111, 1'b1, 4'h0, 4'h0, "nop");
        run_cmd(3'd7, 4'b1111, 1'b1, 4'h0, 4'h0, "reserved");
        run_cmd(3'd5, 4'd0, 1'b1, 4'h0, 4'h0, "count_zero");
        run_cmd(3'd5, 4'd15, 1'b0, '0, '0, "count_max");
    endtask

    task automatic test_back_to_back();
        logic [2:0] op;
        logic [3:0] arg;
        for (int n = 0; n < 8; n++) begin
            op  = 3'($urandom_range(7));
            arg = 4'($urandom_range(15));
            run_cmd(op, arg, 1'b0, '0, '0, "b2b");
        end
    endtask

    task automatic test_reset_mid();
        int dones;
        run_cmd(3'd1, 4'h0, 1'b0, '0, '0, "rm_clear");
        @(negedge clk);
        cmd_op    = 3'd5;
        cmd_arg   = 4'd8;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        total++;
        if (q_fb !== 4'b0011) begin
            bad++;
            $display("FAIL rm_third_settle: q_fb=%b required=0011", q_fb);
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        total++;
        if (j !== 4'h0 || k !== 4'h0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL rm_after_reset: j=%b k=%b busy=%b done=%b required 0 0 0 0", j, k, busy, done);
        end
        dones = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) dones++;
        end
        total++;
        if (dones != 0 || q_fb !== 4'b0011) begin
            bad++;
            $display("FAIL rm_quiet: done_pulses=%0d q_fb=%b required 0 0011", dones, q_fb);
        end
        model_q = 4'b0011;
        run_cmd(3'd5, 4'd1, 1'b1, 4'b0111, 4'b0111, "rm_next");
    endtask

    initial begin
        test_reset();
        test_clear_set();
        test_load();
        test_count_up();
        test_count_down();
        test_toggle_nop();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
